lz77_stream_matcher: RTL and testbench
======================================

LZ77_STREAM_MATCHER -- requirements
Module: lz77_stream_matcher

Interface
REQ-001 SHALL have parameter DATA_W, default 8, symbol width in bits.
REQ-002 SHALL have parameter WIN_DEPTH, default 16, history window depth in symbols (power of 2, >=4).
REQ-003 SHALL have parameter MAX_MATCH, default 8, lookahead depth and longest encodable match (>=MIN_MATCH).
REQ-004 SHALL have parameter MIN_MATCH, default 3, shortest length emitted as a match (>=2).
REQ-005 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 SHALL have ports in_valid, in_ready, in_last (input, output, input; 1 bit each) and in_data (input, DATA_W): symbol stream; in_last marks the final symbol.
REQ-008 SHALL have ports tok_valid (output, 1), tok_ready (input, 1), tok_is_match (output, 1), tok_literal (output, DATA_W), tok_offset (output, OFF_W=clog2(WIN_DEPTH+1)), tok_length (output, LEN_W=clog2(MAX_MATCH+1)) and tok_last (output, 1).
REQ-009 SHALL have ports busy (output, 1: not in FILL with empty lookahead) and done (output, 1: one-cycle pulse after the final token handshake).

Function
REQ-010 SHALL implement FSM states FILL, SEARCH, EMIT, SHIFT.
REQ-011 FILL: in_ready=1 while la_count<MAX_MATCH and no in_last has been accepted; each in_valid&&in_ready appends to lookahead LA[0..la_count-1].
REQ-012 FILL->SEARCH when la_count==MAX_MATCH, or when in_last has been accepted and la_count>0.
REQ-013 History H(1..hist_count) SHALL be indexed newest-first, with hist_count saturating at WIN_DEPTH.
REQ-014 SEARCH SHALL test offsets d=1..hist_count in ascending order, one byte compare per cycle, with per-candidate length l starting at 0.
REQ-015 Reference byte = H(d-l) if l<d, else LA(l-d), so overlapping matches are supported.
REQ-016 On equal with l+1<la_count: l increments. On equal with l+1==la_count, or on mismatch: the candidate length is l+equal.
REQ-017 The best candidate SHALL be replaced only when strictly longer, so the smallest offset wins ties.
REQ-018 SEARCH SHALL end after the last offset, after a candidate reaches la_count (early exit), or immediately if hist_count==0.
REQ-019 EMIT with best_len>=MIN_MATCH: tok_is_match=1, tok_offset=best_off, tok_length=best_len, tok_literal=0.
REQ-020 EMIT otherwise: tok_is_match=0, tok_literal=LA[0], tok_offset=0, tok_length=1.
REQ-021 In EMIT, tok_valid=1 and all tok_* SHALL be held stable until tok_ready; in_ready=0 outside FILL.
REQ-022 tok_last=1 iff in_last was accepted and the token consumes every remaining LA byte.
REQ-023 SHIFT SHALL move one consumed byte per cycle from LA[0] into H(1), shifting LA down, for tok_length cycles, then go to FILL.
REQ-024 After the tok_last handshake and SHIFT, hist_count, la_count and the last flag SHALL clear, and done SHALL pulse for 1 cycle.
REQ-025 Worst-case SEARCH latency SHALL be WIN_DEPTH*MAX_MATCH cycles; EMIT is at least 1 cycle; SHIFT is 1..MAX_MATCH cycles.

Reset
REQ-026 rst low SHALL asynchronously force FILL, la_count=0, hist_count=0, and tok_valid=tok_is_match=tok_last=done=busy=0, with tok_literal/offset/length=0 and in_ready=0 while asserted.
REQ-027 Reset mid-operation SHALL discard the lookahead and history; the next stream starts with empty history.

Structure
REQ-028 Token field widths, FSM state encoding and the OFF_W/LEN_W functions SHALL live in shared package lz77_pkg.
REQ-029 The history+lookahead storage with shift and read-by-distance SHALL be sub-module lz77_window_buf; FSM and compare logic stay in the top.

Verification (WIN_DEPTH=8, MAX_MATCH=4, MIN_MATCH=2, tok_ready=1 unless stated)
REQ-030 "abcabcab" (last on final b) -> lit a, lit b, lit c, match(off 3, len 4), lit b with tok_last=1, then done pulse.
REQ-031 "aaaaa" -> lit a, match(off 1, len 4, tok_last=1) (overlap case).
REQ-032 "abcd" -> four literals, tok_last only on d, no match tokens.
REQ-033 tok_ready=0 for 5 cycles during match(3,4) -> all tok_* unchanged, in_ready=0, then proceeds normally.
REQ-034 Assert rst during SEARCH of "abcabc..." -> all outputs 0 immediately; after release, "ab" -> lit a, lit b (no stale history match).
REQ-035 Stream "xyzq"+"abcdefgh"+"xyzq" -> final xyzq emitted as four literals (distance 12 > WIN_DEPTH).

Source files
------------

// File: rtl/lz77_pkg.sv
// Shared definitions for the LZ77 stream matcher: FSM state encoding and the
// token field width functions used by the top and the window buffer.
package lz77_pkg;

  // Matcher FSM states
  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_EMIT   = 2'd2,
    ST_SHIFT  = 2'd3
  } state_e;

  // Token offset width: must hold distances 0..win_depth
  function automatic int unsigned off_w(input int unsigned win_depth);
    return $clog2(win_depth + 1);
  endfunction

  // Token length width: must hold lengths 0..max_match
  function automatic int unsigned len_w(input int unsigned max_match);
    return $clog2(max_match + 1);
  endfunction

endpackage

// File: rtl/lz77_window_buf.sv
// History + lookahead storage for the LZ77 matcher.
// History is kept newest-first (hist_q[0] = H(1)); lookahead is LA[0..la_count-1].
// Ports:
//   clk, rst        clock, async active-low reset
//   clear           drop all history and lookahead (counts to zero)
//   push/push_data  append one symbol at LA[la_count]
//   shift           move LA[0] into H(1), shift LA down by one
//   la_count        valid lookahead symbols
//   hist_count      valid history symbols (saturates at WIN_DEPTH)
//   hist_dist/data  read H(hist_dist), hist_dist in 1..WIN_DEPTH
//   la_idx_a/data_a read LA(la_idx_a)
//   la_idx_b/data_b read LA(la_idx_b)
//   la_head         LA[0]
module lz77_window_buf
  import lz77_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned WIN_DEPTH = 16,
  parameter int unsigned MAX_MATCH = 8,
  localparam int unsigned OFF_W    = off_w(WIN_DEPTH),
  localparam int unsigned LEN_W    = len_w(MAX_MATCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              shift,
  output logic [LEN_W-1:0]  la_count,
  output logic [OFF_W-1:0]  hist_count,
  input  logic [OFF_W-1:0]  hist_dist,
  output logic [DATA_W-1:0] hist_data,
  input  logic [LEN_W-1:0]  la_idx_a,
  output logic [DATA_W-1:0] la_data_a,
  input  logic [LEN_W-1:0]  la_idx_b,
  output logic [DATA_W-1:0] la_data_b,
  output logic [DATA_W-1:0] la_head
);

  logic [DATA_W-1:0] hist_q [WIN_DEPTH];
  logic [DATA_W-1:0] la_q   [MAX_MATCH];

  // Storage and occupancy; clear wins over shift so the final shift of a
  // stream can also wipe the window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < WIN_DEPTH; i++) hist_q[i] <= '0;
      for (int i = 0; i < MAX_MATCH; i++) la_q[i] <= '0;
      la_count   <= '0;
      hist_count <= '0;
    end else if (clear) begin
      la_count   <= '0;
      hist_count <= '0;
    end else if (shift) begin
      hist_q[0] <= la_q[0];
      for (int i = 1; i < WIN_DEPTH; i++) hist_q[i] <= hist_q[i-1];
      for (int i = 0; i < MAX_MATCH - 1; i++) la_q[i] <= la_q[i+1];
      la_q[MAX_MATCH-1] <= '0;
      la_count <= la_count - LEN_W'(1);
      if (hist_count != OFF_W'(WIN_DEPTH)) hist_count <= hist_count + OFF_W'(1);
    end else if (push) begin
      for (int i = 0; i < MAX_MATCH; i++) begin
        if (la_count == LEN_W'(i)) la_q[i] <= push_data;
      end
      la_count <= la_count + LEN_W'(1);
    end
  end

  // Read-by-distance into history
  always_comb begin
    hist_data = '0;
    for (int i = 0; i < WIN_DEPTH; i++) begin
      if (hist_dist == OFF_W'(i + 1)) hist_data = hist_q[i];
    end
  end

  // Two lookahead read ports
  always_comb begin
    la_data_a = '0;
    la_data_b = '0;
    for (int i = 0; i < MAX_MATCH; i++) begin
      if (la_idx_a == LEN_W'(i)) la_data_a = la_q[i];
      if (la_idx_b == LEN_W'(i)) la_data_b = la_q[i];
    end
  end

  assign la_head = la_q[0];

endmodule

// File: rtl/lz77_stream_matcher.sv
// LZ77 stream matcher: buffers a lookahead, searches the history window one
// byte compare per cycle for the longest (smallest-offset) match, and emits
// literal or match tokens over a valid/ready interface.
// Ports:
//   clk, rst                          clock, async active-low reset
//   in_valid/in_ready/in_last/in_data input symbol stream
//   tok_valid/tok_ready               token handshake
//   tok_is_match, tok_literal, tok_offset, tok_length, tok_last  token payload
//   busy                              high unless idle in FILL with empty lookahead
//   done                              one-cycle pulse after the stream's last token
module lz77_stream_matcher
  import lz77_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned WIN_DEPTH = 16,
  parameter int unsigned MAX_MATCH = 8,
  parameter int unsigned MIN_MATCH = 3,
  localparam int unsigned OFF_W    = off_w(WIN_DEPTH),
  localparam int unsigned LEN_W    = len_w(MAX_MATCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [DATA_W-1:0] in_data,
  output logic              tok_valid,
  input  logic              tok_ready,
  output logic              tok_is_match,
  output logic [DATA_W-1:0] tok_literal,
  output logic [OFF_W-1:0]  tok_offset,
  output logic [LEN_W-1:0]  tok_length,
  output logic              tok_last,
  output logic              busy,
  output logic              done
);

  // Common width for offset/length arithmetic
  localparam int unsigned IDX_W = ((OFF_W > LEN_W) ? OFF_W : LEN_W) + 1;

  state_e state, state_nxt;

  logic              last_seen;
  logic [OFF_W-1:0]  cur_d, best_off, best_off_upd;
  logic [LEN_W-1:0]  cur_l, best_len, best_len_upd, cand_len, shift_rem;

  logic [LEN_W-1:0]  la_count;
  logic [OFF_W-1:0]  hist_count;
  logic [OFF_W-1:0]  hist_dist;
  logic [LEN_W-1:0]  la_idx_a;
  logic [DATA_W-1:0] hist_data, la_data_a, la_data_b, la_head;

  logic [IDX_W-1:0]  d_x, l_x;
  logic              ref_from_hist, equal, extend, no_hist, search_done;
  logic              emit_match;
  logic [LEN_W-1:0]  emit_len;

  logic              push, shift_en, clear, search_start;
  logic [LEN_W-1:0]  la_cnt_nxt;
  logic              last_nxt;
  logic              in_ready_nxt, busy_nxt, done_nxt, tok_valid_nxt;
  logic              tok_is_match_nxt, tok_last_nxt;
  logic [DATA_W-1:0] tok_literal_nxt;
  logic [OFF_W-1:0]  tok_offset_nxt;
  logic [LEN_W-1:0]  tok_length_nxt;

  lz77_window_buf #(
    .DATA_W    (DATA_W),
    .WIN_DEPTH (WIN_DEPTH),
    .MAX_MATCH (MAX_MATCH)
  ) u_win (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .push       (push),
    .push_data  (in_data),
    .shift      (shift_en),
    .la_count   (la_count),
    .hist_count (hist_count),
    .hist_dist  (hist_dist),
    .hist_data  (hist_data),
    .la_idx_a   (la_idx_a),
    .la_data_a  (la_data_a),
    .la_idx_b   (cur_l),
    .la_data_b  (la_data_b),
    .la_head    (la_head)
  );

  // Candidate compare: reference byte comes from history until the match
  // runs past the current position, then from the lookahead itself (overlap).
  always_comb begin
    d_x           = IDX_W'(cur_d);
    l_x           = IDX_W'(cur_l);
    ref_from_hist = l_x < d_x;
    hist_dist     = OFF_W'(d_x - l_x);
    la_idx_a      = LEN_W'(l_x - d_x);
    equal         = (ref_from_hist ? hist_data : la_data_a) == la_data_b;
    extend        = equal && ((cur_l + LEN_W'(1)) < la_count);
    cand_len      = cur_l + LEN_W'(equal);
    no_hist       = hist_count == '0;
    best_len_upd  = best_len;
    best_off_upd  = best_off;
    // Strictly longer only, so the first (smallest) offset wins ties
    if (!no_hist && (cand_len > best_len)) begin
      best_len_upd = cand_len;
      best_off_upd = cur_d;
    end
    search_done = no_hist ||
                  (!extend && ((cand_len == la_count) || (cur_d == hist_count)));
    emit_match  = best_len_upd >= LEN_W'(MIN_MATCH);
    emit_len    = emit_match ? best_len_upd : LEN_W'(1);
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_FILL;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_FILL: begin
        if ((la_count == LEN_W'(MAX_MATCH)) || (last_seen && (la_count != '0)))
          state_nxt = ST_SEARCH;
      end
      ST_SEARCH: if (search_done) state_nxt = ST_EMIT;
      ST_EMIT:   if (tok_ready) state_nxt = ST_SHIFT;
      ST_SHIFT:  if (shift_rem == LEN_W'(1)) state_nxt = ST_FILL;
      default:   state_nxt = ST_FILL;
    endcase
  end

  // Output/control logic: strobes and next values of the registered outputs
  always_comb begin
    push             = (state == ST_FILL) && in_valid && in_ready;
    shift_en         = state == ST_SHIFT;
    // Last shift of the final token: every remaining byte is consumed
    clear            = (state == ST_SHIFT) && (shift_rem == LEN_W'(1)) &&
                       last_seen && (la_count == LEN_W'(1));
    search_start     = (state == ST_FILL) && (state_nxt == ST_SEARCH);

    la_cnt_nxt       = la_count;
    if (clear)         la_cnt_nxt = '0;
    else if (push)     la_cnt_nxt = la_count + LEN_W'(1);
    else if (shift_en) la_cnt_nxt = la_count - LEN_W'(1);
    last_nxt         = !clear && (last_seen || (push && in_last));

    in_ready_nxt     = (state_nxt == ST_FILL) && (la_cnt_nxt < LEN_W'(MAX_MATCH)) &&
                       !last_nxt;
    busy_nxt         = !((state_nxt == ST_FILL) && (la_cnt_nxt == '0));
    done_nxt         = clear;
    tok_valid_nxt    = state_nxt == ST_EMIT;

    tok_is_match_nxt = 1'b0;
    tok_literal_nxt  = '0;
    tok_offset_nxt   = '0;
    tok_length_nxt   = '0;
    tok_last_nxt     = 1'b0;
    if ((state == ST_SEARCH) && search_done) begin
      tok_is_match_nxt = emit_match;
      tok_literal_nxt  = emit_match ? '0 : la_head;
      tok_offset_nxt   = emit_match ? best_off_upd : '0;
      tok_length_nxt   = emit_len;
      tok_last_nxt     = last_seen && (emit_len == la_count);
    end else if ((state == ST_EMIT) && !tok_ready) begin
      tok_is_match_nxt = tok_is_match;
      tok_literal_nxt  = tok_literal;
      tok_offset_nxt   = tok_offset;
      tok_length_nxt   = tok_length;
      tok_last_nxt     = tok_last;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      tok_valid    <= 1'b0;
      tok_is_match <= 1'b0;
      tok_literal  <= '0;
      tok_offset   <= '0;
      tok_length   <= '0;
      tok_last     <= 1'b0;
      last_seen    <= 1'b0;
      cur_d        <= '0;
      cur_l        <= '0;
      best_len     <= '0;
      best_off     <= '0;
      shift_rem    <= '0;
    end else begin
      in_ready     <= in_ready_nxt;
      busy         <= busy_nxt;
      done         <= done_nxt;
      tok_valid    <= tok_valid_nxt;
      tok_is_match <= tok_is_match_nxt;
      tok_literal  <= tok_literal_nxt;
      tok_offset   <= tok_offset_nxt;
      tok_length   <= tok_length_nxt;
      tok_last     <= tok_last_nxt;
      last_seen    <= last_nxt;

      if (search_start) begin
        cur_d    <= OFF_W'(1);
        cur_l    <= '0;
        best_len <= '0;
        best_off <= '0;
      end else if (state == ST_SEARCH) begin
        if (extend) begin
          cur_l <= cur_l + LEN_W'(1);
        end else begin
          cur_l    <= '0;
          cur_d    <= cur_d + OFF_W'(1);
          best_len <= best_len_upd;
          best_off <= best_off_upd;
        end
      end

      if ((state == ST_EMIT) && tok_ready) shift_rem <= tok_length;
      else if (state == ST_SHIFT)          shift_rem <= shift_rem - LEN_W'(1);
    end
  end

endmodule

// File: tb/tb_lz77_stream_matcher.sv
// Directed bench for lz77_stream_matcher (WIN_DEPTH=8, MAX_MATCH=4, MIN_MATCH=2).
module tb_lz77_stream_matcher;

  localparam int unsigned DW = 8;
  localparam int unsigned WD = 8;
  localparam int unsigned MM = 4;
  localparam int unsigned MN = 2;
  localparam int unsigned OW = 4;
  localparam int unsigned LW = 3;

  logic          clk;
  logic          rst;
  logic          in_valid, in_ready, in_last;
  logic [DW-1:0] in_data;
  logic          tok_valid, tok_ready, tok_is_match, tok_last;
  logic [DW-1:0] tok_literal;
  logic [OW-1:0] tok_offset;
  logic [LW-1:0] tok_length;
  logic          busy, done;

  lz77_stream_matcher #(
    .DATA_W(DW), .WIN_DEPTH(WD), .MAX_MATCH(MM), .MIN_MATCH(MN)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last), .in_data(in_data),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_is_match(tok_is_match),
    .tok_literal(tok_literal), .tok_offset(tok_offset), .tok_length(tok_length),
    .tok_last(tok_last), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit            is_match;
    logic [DW-1:0] lit;
    int            off;
    int            len;
    bit            last;
  } tok_rec_t;

  tok_rec_t tab [40];
  int       nt;
  int       case_first [6];
  int       case_cnt   [6];
  string    case_src   [6];

  int checks;
  int failures;

  function automatic tok_rec_t mk_lit(input byte c, input bit last);
    tok_rec_t r;
    r.is_match = 1'b0; r.lit = c; r.off = 0; r.len = 1; r.last = last;
    return r;
  endfunction

  function automatic tok_rec_t mk_mat(input int off, input int len, input bit last);
    tok_rec_t r;
    r.is_match = 1'b1; r.lit = '0; r.off = off; r.len = len; r.last = last;
    return r;
  endfunction

  task automatic add(input tok_rec_t r);
    tab[nt] = r;
    nt++;
  endtask

  task automatic check(input bit ok, input string name, input string act, input string req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %s, expected %s", name, act, req);
    end
  endtask

  function automatic string tok_str();
    return $sformatf("m=%0d lit=%h off=%0d len=%0d last=%0d",
                     tok_is_match, tok_literal, tok_offset, tok_length, tok_last);
  endfunction

  function automatic string rec_str(input tok_rec_t e);
    return $sformatf("m=%0d lit=%h off=%0d len=%0d last=%0d",
                     e.is_match, e.lit, e.off, e.len, e.last);
  endfunction

  // Feed case k's source, consume and compare its tokens. stall_n holds
  // tok_ready low that many cycles on each match token; abort_after >= 0
  // returns mid-stream a few cycles after that many tokens were taken.
  task automatic run_case(input int k, input int stall_n, input int abort_after);
    int       si, ti, cyc, stall, post, n_src, n_exp, base;
    bit       got_done, ok;
    string    src;
    tok_rec_t e;
    si = 0; ti = 0; cyc = 0; stall = 0; post = 0; got_done = 1'b0;
    src = case_src[k]; n_src = src.len(); n_exp = case_cnt[k]; base = case_first[k];
    tok_ready = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    while (cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        check(ti == n_exp, "done_after_last_token", $sformatf("tokens=%0d", ti),
              $sformatf("tokens=%0d", n_exp));
        got_done = 1'b1;
      end
      tok_ready = 1'b1;
      if (tok_valid) begin
        check(ti < n_exp, "extra_token", $sformatf("token#%0d", ti),
              $sformatf("at most %0d tokens", n_exp));
        if (ti < n_exp) begin
          e  = tab[base + ti];
          ok = (tok_is_match == e.is_match) && (tok_literal == e.lit) &&
               (int'(tok_offset) == e.off) && (int'(tok_length) == e.len) &&
               (tok_last == e.last);
          if (stall_n > 0 && e.is_match && stall < stall_n) begin
            check(ok, $sformatf("stall_hold_c%0d_t%0d", k, ti), tok_str(), rec_str(e));
            check(in_ready == 1'b0, "in_ready_during_emit", $sformatf("%0d", in_ready), "0");
            tok_ready = 1'b0;
            stall++;
          end else begin
            check(ok, $sformatf("token_c%0d_t%0d", k, ti), tok_str(), rec_str(e));
            check(busy == 1'b1, "busy_during_emit", $sformatf("%0d", busy), "1");
            ti++;
          end
        end
      end
      if (si < n_src) begin
        in_valid = 1'b1;
        in_data  = src[si];
        in_last  = (si == n_src - 1);
        if (in_ready) si++;
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      if (abort_after >= 0 && ti >= abort_after) begin
        post++;
        if (post == 6) return;
      end
      if (got_done) break;
    end
    check(got_done, $sformatf("done_seen_c%0d", k), $sformatf("%0d", got_done), "1");
    if (stall_n > 0)
      check(stall == stall_n, "stall_cycles", $sformatf("%0d", stall), $sformatf("%0d", stall_n));
    @(negedge clk);
    check(done == 1'b0, "done_one_cycle", $sformatf("%0d", done), "0");
    check(busy == 1'b0, "busy_idle", $sformatf("%0d", busy), "0");
    check(in_ready == 1'b1, "in_ready_idle", $sformatf("%0d", in_ready), "1");
  endtask

  task automatic check_reset_outputs(input string tag);
    check(in_ready == 1'b0, {tag, "_in_ready"}, $sformatf("%0d", in_ready), "0");
    check(tok_valid == 1'b0 && tok_is_match == 1'b0 && tok_last == 1'b0,
          {tok_str(), ""} == "" ? tag : {tag, "_tok_flags"}, tok_str(), "all flags 0");
    check(tok_literal == '0 && tok_offset == '0 && tok_length == '0,
          {tag, "_tok_fields"}, tok_str(), "lit=00 off=0 len=0");
    check(done == 1'b0 && busy == 1'b0, {tag, "_done_busy"},
          $sformatf("done=%0d busy=%0d", done, busy), "done=0 busy=0");
  endtask

  initial begin
    checks = 0; failures = 0; nt = 0;
    in_valid = 1'b0; in_last = 1'b0; in_data = '0; tok_ready = 1'b1;

    // Expected token table
    case_first[0] = nt; case_src[0] = "abcabcab";
    add(mk_lit("a", 0)); add(mk_lit("b", 0)); add(mk_lit("c", 0));
    add(mk_mat(3, 4, 0)); add(mk_lit("b", 1));
    case_cnt[0] = nt - case_first[0];

    case_first[1] = nt; case_src[1] = "aaaaa";
    add(mk_lit("a", 0)); add(mk_mat(1, 4, 1));
    case_cnt[1] = nt - case_first[1];

    case_first[2] = nt; case_src[2] = "abcd";
    add(mk_lit("a", 0)); add(mk_lit("b", 0)); add(mk_lit("c", 0)); add(mk_lit("d", 1));
    case_cnt[2] = nt - case_first[2];

    case_first[3] = nt; case_src[3] = "xyzqabcdefghxyzq";
    for (int i = 0; i < 16; i++) add(mk_lit(case_src[3][i], i == 15));
    case_cnt[3] = nt - case_first[3];

    case_first[4] = nt; case_src[4] = "ab";
    add(mk_lit("a", 0)); add(mk_lit("b", 1));
    case_cnt[4] = nt - case_first[4];

    // Reset behaviour
    rst = 1'b1;
    #3 rst = 1'b0;
    #2 check_reset_outputs("reset_async");
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_held");
    rst = 1'b1;

    run_case(0, 0, -1);
    run_case(1, 0, -1);
    run_case(2, 0, -1);
    run_case(3, 0, -1);
    run_case(0, 5, -1);

    // Reset while searching for the match in "abcabc..."
    run_case(0, 0, 3);
    check(busy == 1'b1 && tok_valid == 1'b0, "pre_reset_searching",
          $sformatf("busy=%0d tok_valid=%0d", busy, tok_valid), "busy=1 tok_valid=0");
    rst = 1'b0;
    #1 check_reset_outputs("reset_mid_search");
    in_valid = 1'b0; in_last = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run_case(4, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
